soc_system_clken_gen: RTL and testbench



---
 rtl/soc_system_clk_pkg.sv | 23 ++
 rtl/soc_system_clken_chan.sv | 88 ++++++++
 rtl/soc_system_clken_gen.sv | 147 ++++++++++++++
 tb/tb_soc_system_clken_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/soc_system_clk_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
//   clkgen_state_t : lock/settle FSM encoding
//   eff_div        : effective divide ratio, max(d,1)
//   clamp_phase    : phase offset limited to the last count of the period
package soc_system_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } clkgen_state_t;

    function automatic int unsigned eff_div(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int unsigned clamp_phase(input int unsigned p, input int unsigned d);
        int unsigned de;
        de = eff_div(d);
        return (p > de - 1) ? de - 1 : p;
    endfunction

endpackage

// File: rtl/soc_system_clken_chan.sv
// One divider channel: divide/phase registers, wrapping counter and the
// registered clk_en / clk_div outputs.
//   clk         : reference clock
//   rst_n       : async active-low reset (already synchronised on release)
//   i_load      : phase-load the counter this cycle
//   i_count     : advance the counter this cycle
//   i_wr        : capture i_wr_div / i_wr_phase (always paired with i_load)
//   i_wr_div    : new divide ratio
//   i_wr_phase  : new phase offset
//   o_clk_en    : one-cycle pulse when counter sits at De-1
//   o_clk_div   : divided square wave, high while counter < De>>1
module soc_system_clken_chan
    import soc_system_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_count,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic [DIV_W-1:0] i_wr_phase,
    output logic             o_clk_en,
    output logic             o_clk_div
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk_en;
    logic             r_clk_div;

    logic [DIV_W-1:0] w_div_src;
    logic [DIV_W-1:0] w_phase_src;
    logic [DIV_W-1:0] w_cnt_nxt;
    int unsigned      w_de;
    int unsigned      w_de_nxt;

    // A write loads from the incoming values so the new phase takes effect
    // on the same edge the registers are updated.
    assign w_div_src   = i_wr ? i_wr_div   : r_div;
    assign w_phase_src = i_wr ? i_wr_phase : r_phase;

    always_comb begin
        w_de      = eff_div(32'(r_div));
        w_de_nxt  = eff_div(32'(w_div_src));
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = DIV_W'(clamp_phase(32'(w_phase_src), 32'(w_div_src)));
        end else if (i_count) begin
            if (32'(r_cnt) >= w_de - 1) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= DIV_W'(DEFAULT_DIV);
            r_phase   <= '0;
            r_cnt     <= '0;
            r_clk_en  <= 1'b0;
            r_clk_div <= 1'b0;
        end else begin
            if (i_wr) begin
                r_div   <= i_wr_div;
                r_phase <= i_wr_phase;
            end
            r_cnt <= w_cnt_nxt;
            // Outputs follow the next-state counter so they line up with cnt;
            // when halted the enable is squelched and the square wave holds.
            if (i_load || i_count) begin
                r_clk_en  <= (32'(w_cnt_nxt) == w_de_nxt - 1);
                r_clk_div <= (32'(w_cnt_nxt) < (w_de_nxt >> 1));
            end else begin
                r_clk_en  <= 1'b0;
            end
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_clk_div = r_clk_div;

endmodule

// File: rtl/soc_system_clken_gen.sv
// Multi-channel clock-enable generator with lock/settle reporting.
//   refclk    : sole clock
//   rst_n     : async active-low reset, release synchronised with 2 flops
//   enable    : global run, low halts every channel
//   cfg_valid : reconfiguration request
//   cfg_ready : reconfiguration accepted this cycle (only while locked)
//   cfg_chan  : target channel of a reconfiguration
//   cfg_div   : new divide ratio
//   cfg_phase : new phase offset
//   clk_en    : per-channel one-cycle enable pulse
//   clk_div   : per-channel divided square wave
//   locked    : all channels running and settled
//
// state      | meaning
// ST_IDLE    | halted, counters frozen, clk_en forced low
// ST_SETTLE  | channels counting, waiting out the settle window
// ST_LOCKED  | outputs stable, reconfiguration accepted
module soc_system_clken_gen
    import soc_system_clk_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic [N_CH-1:0]  clk_en,
    output logic [N_CH-1:0]  clk_div,
    output logic             locked
);

    localparam int SET_W = $clog2(LOCK_CYCLES + 1);

    logic [1:0]     r_rst_sync;
    logic           w_rst_n;
    clkgen_state_t  r_state;
    clkgen_state_t  w_state_nxt;
    logic [SET_W-1:0] r_settle;
    logic [SET_W-1:0] w_settle_nxt;
    logic           r_locked;
    logic           r_cfg_ready;
    logic           w_hs;
    logic           w_chan_ok;
    logic           w_start;
    logic           w_run;

    // Assertion passes straight through; release waits two refclk edges.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    // enable low wins over a simultaneous handshake, so the write is dropped.
    assign w_hs      = cfg_valid && r_cfg_ready && enable;
    assign w_chan_ok = (32'(cfg_chan) < N_CH);
    assign w_start   = (r_state == ST_IDLE) && enable;
    assign w_run     = (r_state != ST_IDLE) && enable;

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                end
            end
            ST_SETTLE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_settle == SET_W'(LOCK_CYCLES)) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_settle_nxt = r_settle + SET_W'(1);
                end
            end
            ST_LOCKED: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hs) begin
                    // Out-of-range channel still completes and re-settles.
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge refclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_settle    <= '0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= w_settle_nxt;
            r_locked    <= (w_state_nxt == ST_LOCKED);
            r_cfg_ready <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign locked    = r_locked;
    assign cfg_ready = r_cfg_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        logic w_sel;
        logic w_load;
        logic w_count;

        assign w_sel   = w_hs && w_chan_ok && (32'(cfg_chan) == g);
        assign w_load  = w_start || w_sel;
        assign w_count = w_run && !w_sel;

        soc_system_clken_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk        (refclk),
            .rst_n      (w_rst_n),
            .i_load     (w_load),
            .i_count    (w_count),
            .i_wr       (w_sel),
            .i_wr_div   (cfg_div),
            .i_wr_phase (cfg_phase),
            .o_clk_en   (clk_en[g]),
            .o_clk_div  (clk_div[g])
        );
    end

endmodule

// File: tb/tb_soc_system_clken_gen.sv
// Directed bench for soc_system_clken_gen (N_CH=4, DIV_W=8, LOCK_CYCLES=16).
module tb_soc_system_clken_gen;

    localparam int N_CH  = 4;
    localparam int DIV_W = 8;
    localparam int LOCK  = 16;

    logic             refclk;
    logic             rst_n;
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_chan;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic [N_CH-1:0]  clk_en;
    logic [N_CH-1:0]  clk_div;
    logic             locked;

    int n_err;
    int n_chk;

    // Expected per-channel waveform: counter restarted at edge s[i] from
    // phase ph[i] with effective ratio de[i] (all clamps precomputed by hand).
    int s  [N_CH];
    int de [N_CH];
    int ph [N_CH];
    int lw;
    logic [N_CH-1:0] e_en;
    logic [N_CH-1:0] e_div;
    logic [N_CH-1:0] held_div;

    soc_system_clken_gen #(
        .N_CH        (N_CH),
        .DIV_W       (DIV_W),
        .LOCK_CYCLES (LOCK),
        .DEFAULT_DIV (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .clk_en    (clk_en),
        .clk_div   (clk_div),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input int d, input int p);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_div   = DIV_W'(d);
        cfg_phase = DIV_W'(p);
    endtask

    function automatic void model(input int m);
        int c;
        for (int i = 0; i < N_CH; i++) begin
            c        = (ph[i] + m - s[i]) % de[i];
            e_en[i]  = (c == de[i] - 1);
            e_div[i] = (c < de[i] / 2);
        end
    endfunction

    task automatic check_run(input string tag, input int m);
        model(m);
        chk({tag, "_clk_en"},  32'(clk_en),  32'(e_en));
        chk({tag, "_clk_div"}, 32'(clk_div), 32'(e_div));
        chk({tag, "_locked"},  32'(locked),    32'((m - lw) >= LOCK + 1));
        chk({tag, "_ready"},   32'(cfg_ready), 32'((m - lw) >= LOCK + 1));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clk_en"},  32'(clk_en),    32'(0));
        chk({tag, "_clk_div"}, 32'(clk_div),   32'(0));
        chk({tag, "_locked"},  32'(locked),    32'(0));
        chk({tag, "_ready"},   32'(cfg_ready), 32'(0));
    endtask

    initial begin
        n_err     = 0;
        n_chk     = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_div   = '0;
        cfg_phase = '0;

        repeat (2) step();
        check_zero("reset");
        rst_n = 1'b1;
        repeat (3) step();
        check_zero("idle");

        // Edge 0 is the enable edge; writes at edges 21, 41, 61, 81.
        for (int i = 0; i < N_CH; i++) begin
            s[i] = 0; de[i] = 2; ph[i] = 0;
        end
        lw = 0;
        enable = 1'b1;
        for (int m = 0; m <= 100; m++) begin
            step();
            cfg_valid = 1'b0;
            case (m)
                21: begin s[1] = 21; de[1] = 5; ph[1] = 3; lw = 21; end
                41: begin s[2] = 41; de[2] = 1; ph[2] = 0; lw = 41; end
                61: begin s[2] = 61; de[2] = 1; ph[2] = 0; lw = 61; end
                81: begin s[3] = 81; de[3] = 4; ph[3] = 3; lw = 81; end
                default: ;
            endcase
            check_run("run", m);
            case (m)
                20: set_cfg(1, 5, 3);
                40: set_cfg(2, 0, 7);
                60: set_cfg(2, 1, 7);
                80: set_cfg(3, 4, 9);
                default: ;
            endcase
        end

        // enable drops on the same edge as a handshake: write must be lost.
        model(100);
        held_div = e_div;
        enable = 1'b0;
        set_cfg(0, 3, 1);
        for (int j = 0; j < 5; j++) begin
            step();
            cfg_valid = 1'b0;
            chk("halt_clk_en",  32'(clk_en),    32'(0));
            chk("halt_clk_div", 32'(clk_div),   32'(held_div));
            chk("halt_locked",  32'(locked),    32'(0));
            chk("halt_ready",   32'(cfg_ready), 32'(0));
        end

        // Re-enable: every channel restarts from its stored phase.
        for (int i = 0; i < N_CH; i++) s[i] = 0;
        lw = 0;
        enable = 1'b1;
        for (int m = 0; m <= 20; m++) begin
            step();
            check_run("restart", m);
        end

        // ch0 to D=6, relock, then async reset mid-cycle.
        set_cfg(0, 6, 0);
        step();
        cfg_valid = 1'b0;
        repeat (LOCK + 1) step();
        chk("d6_locked",   32'(locked),    32'(1));
        chk("d6_clk_en0",  32'(clk_en[0]), 32'(1));
        chk("d6_clk_div0", 32'(clk_div[0]), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        enable = 1'b0;
        repeat (2) step();
        check_zero("rst_hold");
        rst_n = 1'b1;
        repeat (3) step();
        check_zero("rst_release");

        enable = 1'b1;
        for (int m = 0; m <= LOCK + 1; m++) begin
            step();
            chk("post_rst_en0",  32'(clk_en[0]),  32'((m % 2) == 1));
            chk("post_rst_div0", 32'(clk_div[0]), 32'((m % 2) == 0));
            chk("post_rst_locked", 32'(locked),    32'(m >= LOCK + 1));
            chk("post_rst_ready",  32'(cfg_ready), 32'(m >= LOCK + 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
